// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: rebuilds four channels from the serial word
// stream and publishes them together once per complete frame, tracking frame lock.
module tdm_demux4 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            E,
    input  logic [DW-1:0]   D,
    input  logic            FS,
    output logic [4*DW-1:0] Y,
    output logic            V,
    output logic [1:0]      S,
    output logic            LOCK,
    output logic            ERR
);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [DW-1:0] shadow0;
    logic [DW-1:0] shadow1;
    logic [DW-1:0] shadow2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HUNT;
            Y       <= '0;
            V       <= 1'b0;
            S       <= 2'd0;
            LOCK    <= 1'b0;
            ERR     <= 1'b0;
            shadow0 <= '0;
            shadow1 <= '0;
            shadow2 <= '0;
        end else begin
            V   <= 1'b0;
            ERR <= 1'b0;
            if (E) begin
                case (state)
                    HUNT: begin
                        if (FS) begin
                            shadow0 <= D;
                            S       <= 2'd1;
                            state   <= RUN;
                            LOCK    <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (FS) begin
                            // FS anywhere but slot 0 restarts the frame; the partial frame is dropped.
                            if (S != 2'd0) ERR <= 1'b1;
                            shadow0 <= D;
                            S       <= 2'd1;
                        end else if (S == 2'd0) begin
                            ERR   <= 1'b1;
                            state <= HUNT;
                            LOCK  <= 1'b0;
                            S     <= 2'd0;
                        end else begin
                            case (S)
                                2'd1:    shadow1 <= D;
                                2'd2:    shadow2 <= D;
                                default: begin
                                    // Slot 3 completes the frame: publish all four words at once.
                                    Y <= {D, shadow2, shadow1, shadow0};
                                    V <= 1'b1;
                                end
                            endcase
                            S <= 2'(S + 2'd1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: lock, back-to-back frames, stalls, early/missing
// sync, and asynchronous reset mid-frame.
module tb_tdm_demux4;

    logic        clk;
    logic        rst;
    logic        E;
    logic [7:0]  D;
    logic        FS;
    logic [31:0] Y;
    logic        V;
    logic [1:0]  S;
    logic        LOCK;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.DW(8)) dut (
        .clk(clk), .rst(rst), .E(E), .D(D), .FS(FS),
        .Y(Y), .V(V), .S(S), .LOCK(LOCK), .ERR(ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] y, input logic v,
                              input logic [1:0] s, input logic lk, input logic er);
        chk({tag, ".Y"}, Y, y);
        chk({tag, ".V"}, 32'(V), 32'(v));
        chk({tag, ".S"}, 32'(S), 32'(s));
        chk({tag, ".LOCK"}, 32'(LOCK), 32'(lk));
        chk({tag, ".ERR"}, 32'(ERR), 32'(er));
    endtask

    // Drive one cycle's inputs, let the rising edge take them, then sample 1 time unit later.
    task automatic cyc(input logic e, input logic fs, input logic [7:0] d);
        E = e; FS = fs; D = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; E = 1'b0; FS = 1'b0; D = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // HUNT drops words without FS
        cyc(1'b1, 1'b0, 8'h99);
        expect_out("hunt_drop", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Test 1: first lock and frame
        cyc(1'b1, 1'b1, 8'h11);
        expect_out("t1_s0", 32'h0, 1'b0, 2'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h22);
        expect_out("t1_s1", 32'h0, 1'b0, 2'd2, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h33);
        expect_out("t1_s2", 32'h0, 1'b0, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h44);
        expect_out("t1_done", 32'h44332211, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        expect_out("t1_vpulse", 32'h44332211, 1'b0, 2'd0, 1'b1, 1'b0);

        // Test 2: three back-to-back frames
        cyc(1'b1, 1'b1, 8'h81);
        expect_out("t2_f0_s0", 32'h44332211, 1'b0, 2'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h82);
        cyc(1'b1, 1'b0, 8'h83);
        cyc(1'b1, 1'b0, 8'h84);
        expect_out("t2_f0", 32'h84838281, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h91);
        expect_out("t2_f1_s0", 32'h84838281, 1'b0, 2'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h92);
        cyc(1'b1, 1'b0, 8'h93);
        expect_out("t2_f1_s2", 32'h84838281, 1'b0, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h94);
        expect_out("t2_f1", 32'h94939291, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'hA1);
        cyc(1'b1, 1'b0, 8'hA2);
        cyc(1'b1, 1'b0, 8'hA3);
        cyc(1'b1, 1'b0, 8'hA4);
        expect_out("t2_f2", 32'hA4A3A2A1, 1'b1, 2'd0, 1'b1, 1'b0);

        // Test 3: E low for two cycles mid-frame (FS while E=0 is ignored)
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b0, 8'hFF);
        expect_out("t3_stall1", 32'hA4A3A2A1, 1'b0, 2'd2, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'hEE);
        expect_out("t3_stall2", 32'hA4A3A2A1, 1'b0, 2'd2, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h33);
        expect_out("t3_s2", 32'hA4A3A2A1, 1'b0, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h44);
        expect_out("t3_done", 32'h44332211, 1'b1, 2'd0, 1'b1, 1'b0);

        // Test 4: early FS at S=2, then early FS at S=3
        cyc(1'b1, 1'b1, 8'hC1);
        cyc(1'b1, 1'b0, 8'hC2);
        cyc(1'b1, 1'b1, 8'hB1);
        expect_out("t4_early2", 32'h44332211, 1'b0, 2'd1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 8'hB2);
        expect_out("t4_errpulse", 32'h44332211, 1'b0, 2'd2, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'hB3);
        cyc(1'b1, 1'b0, 8'hB4);
        expect_out("t4_newframe", 32'hB4B3B2B1, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'hC1);
        cyc(1'b1, 1'b0, 8'hC2);
        cyc(1'b1, 1'b0, 8'hC3);
        cyc(1'b1, 1'b1, 8'hD1);
        expect_out("t4_early3", 32'hB4B3B2B1, 1'b0, 2'd1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 8'hD2);
        cyc(1'b1, 1'b0, 8'hD3);
        cyc(1'b1, 1'b0, 8'hD4);
        expect_out("t4_frame3", 32'hD4D3D2D1, 1'b1, 2'd0, 1'b1, 1'b0);

        // Test 5: missing FS at slot 0 drops lock
        cyc(1'b1, 1'b0, 8'h77);
        expect_out("t5_lost", 32'hD4D3D2D1, 1'b0, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h78);
        expect_out("t5_hunt", 32'hD4D3D2D1, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h79);
        cyc(1'b1, 1'b1, 8'h01);
        expect_out("t5_relock", 32'hD4D3D2D1, 1'b0, 2'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b1, 1'b0, 8'h04);
        expect_out("t5_frame", 32'h04030201, 1'b1, 2'd0, 1'b1, 1'b0);

        // Test 6: asynchronous reset mid-frame at S=2
        cyc(1'b1, 1'b1, 8'hE1);
        cyc(1'b1, 1'b0, 8'hE2);
        expect_out("t6_pre", 32'h04030201, 1'b0, 2'd2, 1'b1, 1'b0);
        E = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_out("t6_async", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b1, 8'hF1);
        cyc(1'b1, 1'b0, 8'hF2);
        cyc(1'b1, 1'b0, 8'hF3);
        expect_out("t6_partial", 32'h0, 1'b0, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'hF4);
        expect_out("t6_frame", 32'hF4F3F2F1, 1'b1, 2'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
